// File: rtl/register_file_mp_pkg.sv
// Shared definitions for the MIPS multi-port register file: sequencer state
// encodings and the core's default geometry.
package register_file_mp_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DUMP  = 2'd2
  } rf_state_e;

  localparam int MIPS_NUM_BITS = 32;
  localparam int MIPS_NUM_REGS = 32;

endpackage

// File: rtl/rf_dump_sequencer.sv
// Control side of the register file: clear sweep after reset or request, and the
// valid/ready dump stream that walks every register address in order.
module rf_dump_sequencer
  import register_file_mp_pkg::*;
#(
  parameter int NUM_REGS  = MIPS_NUM_REGS,
  parameter int TAM_DIREC = $clog2(NUM_REGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 dump_start_i,
  input  logic                 dump_ready_i,
  output logic                 ready_o,
  output logic                 clr_we_o,
  output logic [TAM_DIREC-1:0] clr_addr_o,
  output logic                 dump_cap_o,
  output logic [TAM_DIREC-1:0] dump_rd_addr_o,
  output logic                 dump_valid_o,
  output logic [TAM_DIREC-1:0] dump_addr_o,
  output logic                 dump_last_o
);

  localparam logic [TAM_DIREC-1:0] LAST      = TAM_DIREC'(NUM_REGS - 1);
  localparam logic [TAM_DIREC-1:0] FIRST_CLR = TAM_DIREC'(1);
  localparam logic [TAM_DIREC-1:0] ONE       = TAM_DIREC'(1);

  rf_state_e            state_q, state_d;
  logic [TAM_DIREC-1:0] clr_ptr_q, clr_ptr_d;
  logic [TAM_DIREC-1:0] dump_addr_q, dump_addr_d;
  logic                 dump_valid_q, dump_valid_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_CLEAR;
      clr_ptr_q    <= FIRST_CLR;
      dump_addr_q  <= '0;
      dump_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      dump_addr_q  <= dump_addr_d;
      dump_valid_q <= dump_valid_d;
    end
  end

  // dump_cap_o tells the array side to load the word at dump_rd_addr_o on this edge.
  always_comb begin
    state_d        = state_q;
    clr_ptr_d      = clr_ptr_q;
    dump_addr_d    = dump_addr_q;
    dump_valid_d   = dump_valid_q;
    dump_cap_o     = 1'b0;
    dump_rd_addr_o = dump_addr_q + ONE;
    unique case (state_q)
      ST_CLEAR: begin
        dump_valid_d = 1'b0;
        clr_ptr_d    = clr_ptr_q + ONE;
        if (clr_ptr_q == LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear_i) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = FIRST_CLR;
        end else if (dump_start_i) begin
          state_d        = ST_DUMP;
          dump_valid_d   = 1'b1;
          dump_addr_d    = '0;
          dump_cap_o     = 1'b1;
          dump_rd_addr_o = '0;
        end
      end
      ST_DUMP: begin
        if (clear_i) begin
          state_d      = ST_CLEAR;
          clr_ptr_d    = FIRST_CLR;
          dump_valid_d = 1'b0;
        end else if (dump_valid_q && dump_ready_i) begin
          if (dump_addr_q == LAST) begin
            dump_valid_d = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            dump_addr_d = dump_addr_q + ONE;
            dump_cap_o  = 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign ready_o      = (state_q != ST_CLEAR);
  assign clr_we_o     = (state_q == ST_CLEAR);
  assign clr_addr_o   = clr_ptr_q;
  assign dump_valid_o = dump_valid_q;
  assign dump_addr_o  = dump_addr_q;
  assign dump_last_o  = dump_valid_q && (dump_addr_q == LAST);

endmodule

// File: rtl/register_file_mp.sv
// Multi-port MIPS register file: byte-maskable write port, registered read ports
// with write-first bypass, r0 hardwired to zero, plus clear/dump sequencing.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int NUM_BITS       = MIPS_NUM_BITS,
  parameter int NUM_REGS       = MIPS_NUM_REGS,
  parameter int NUM_READ_PORTS = 2,
  parameter int TAM_DIREC      = $clog2(NUM_REGS)
) (
  input  logic                                i_clk,
  input  logic                                i_reset_n,
  input  logic                                i_write_enable,
  input  logic [NUM_BITS/8-1:0]               i_write_strobe,
  input  logic [TAM_DIREC-1:0]                i_write_direc,
  input  logic [NUM_BITS-1:0]                 i_data,
  input  logic [NUM_READ_PORTS*TAM_DIREC-1:0] i_read_direc,
  output logic [NUM_READ_PORTS*NUM_BITS-1:0]  o_data,
  input  logic                                i_clear,
  output logic                                o_ready,
  input  logic                                i_dump_start,
  output logic                                o_dump_valid,
  input  logic                                i_dump_ready,
  output logic [TAM_DIREC-1:0]                o_dump_addr,
  output logic [NUM_BITS-1:0]                 o_dump_data,
  output logic                                o_dump_last
);

  logic                 ready;
  logic                 clr_we;
  logic [TAM_DIREC-1:0] clr_addr;
  logic                 dump_cap;
  logic [TAM_DIREC-1:0] dump_rd_addr;

  logic [NUM_BITS-1:0]                     mem_q [NUM_REGS];
  logic [NUM_READ_PORTS-1:0][NUM_BITS-1:0] rd_data_q, rd_data_d;
  logic [NUM_BITS-1:0]                     dump_data_q, dump_data_d;
  logic                                    wr_act;
  logic [NUM_BITS-1:0]                     wr_word;

  rf_dump_sequencer #(
    .NUM_REGS  (NUM_REGS),
    .TAM_DIREC (TAM_DIREC)
  ) u_seq (
    .clk_i          (i_clk),
    .rst_ni         (i_reset_n),
    .clear_i        (i_clear),
    .dump_start_i   (i_dump_start),
    .dump_ready_i   (i_dump_ready),
    .ready_o        (ready),
    .clr_we_o       (clr_we),
    .clr_addr_o     (clr_addr),
    .dump_cap_o     (dump_cap),
    .dump_rd_addr_o (dump_rd_addr),
    .dump_valid_o   (o_dump_valid),
    .dump_addr_o    (o_dump_addr),
    .dump_last_o    (o_dump_last)
  );

  // r0 and addresses beyond a non-power-of-2 depth always read as zero.
  function automatic logic [NUM_BITS-1:0] rd_raw(input logic [TAM_DIREC-1:0] addr);
    if (addr == '0 || 32'(addr) >= NUM_REGS) return '0;
    return mem_q[addr];
  endfunction

  function automatic logic [NUM_BITS-1:0] merge_bytes(input logic [NUM_BITS-1:0]   old_w,
                                                      input logic [NUM_BITS-1:0]   new_w,
                                                      input logic [NUM_BITS/8-1:0] strb);
    logic [NUM_BITS-1:0] res;
    res = old_w;
    for (int k = 0; k < NUM_BITS / 8; k++) begin
      if (strb[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  assign wr_act  = i_write_enable && ready && (i_write_direc != '0) &&
                   (32'(i_write_direc) < NUM_REGS);
  assign wr_word = merge_bytes(rd_raw(i_write_direc), i_data, i_write_strobe);

  always_comb begin
    rd_data_d = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      if (ready) begin
        if (wr_act && (i_read_direc[p*TAM_DIREC +: TAM_DIREC] == i_write_direc))
          rd_data_d[p] = wr_word;
        else
          rd_data_d[p] = rd_raw(i_read_direc[p*TAM_DIREC +: TAM_DIREC]);
      end
    end
  end

  // Dump word is captured once on presentation so later writes cannot disturb a stalled word.
  always_comb begin
    dump_data_d = dump_data_q;
    if (dump_cap) begin
      if (wr_act && (dump_rd_addr == i_write_direc)) dump_data_d = wr_word;
      else                                           dump_data_d = rd_raw(dump_rd_addr);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_data_q   <= '0;
      dump_data_q <= '0;
    end else begin
      rd_data_q   <= rd_data_d;
      dump_data_q <= dump_data_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (clr_we)      mem_q[clr_addr]      <= '0;
    else if (wr_act) mem_q[i_write_direc] <= wr_word;
  end

  assign o_data      = rd_data_q;
  assign o_ready     = ready;
  assign o_dump_data = dump_data_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: behavioural array/dump model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_register_file_mp;
  localparam int NB = 32, NR = 32, NP = 2, AW = 5, NS = NB / 8, RW = NP * AW;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_write_enable;
  logic [NS-1:0] i_write_strobe;
  logic [AW-1:0] i_write_direc;
  logic [NB-1:0] i_data;
  logic [RW-1:0] i_read_direc;
  logic [NP*NB-1:0] o_data;
  logic          i_clear, o_ready, i_dump_start, o_dump_valid, i_dump_ready, o_dump_last;
  logic [AW-1:0] o_dump_addr;
  logic [NB-1:0] o_dump_data;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  always #5 i_clk = ~i_clk;

  register_file_mp #(.NUM_BITS(NB), .NUM_REGS(NR), .NUM_READ_PORTS(NP), .TAM_DIREC(AW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_write_enable(i_write_enable),
    .i_write_strobe(i_write_strobe), .i_write_direc(i_write_direc), .i_data(i_data),
    .i_read_direc(i_read_direc), .o_data(o_data), .i_clear(i_clear), .o_ready(o_ready),
    .i_dump_start(i_dump_start), .o_dump_valid(o_dump_valid), .i_dump_ready(i_dump_ready),
    .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data), .o_dump_last(o_dump_last)
  );

  // Model: contents as a plain array, mode 0=clearing 1=idle 2=dumping.
  logic [NB-1:0] mem [NR];
  logic [NB-1:0] ed [NP];
  int            mode = 0;
  int            left = NR - 1;
  int            da = 0;
  bit            dv = 0;
  logic [NB-1:0] dd = '0;

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic enter_clear();
    mode = 0; left = NR - 1; dv = 0;
    for (int r = 0; r < NR; r++) mem[r] = '0;
  endtask

  task automatic model_reset();
    enter_clear();
    da = 0; dd = '0;
    for (int p = 0; p < NP; p++) ed[p] = '0;
  endtask

  task automatic model_step();
    int wa, ra;
    bit wr;
    wa = int'(i_write_direc);
    wr = i_write_enable && mode != 0 && wa != 0 && wa < NR;
    if (wr) for (int k = 0; k < NS; k++) if (i_write_strobe[k]) mem[wa][8*k +: 8] = i_data[8*k +: 8];
    for (int p = 0; p < NP; p++) begin
      ra = int'(i_read_direc[p*AW +: AW]);
      ed[p] = (mode == 0) ? '0 : mem[ra];
    end
    case (mode)
      0: begin left--; if (left == 0) mode = 1; end
      1: if (i_clear) enter_clear();
         else if (i_dump_start) begin mode = 2; dv = 1; da = 0; dd = mem[0]; end
      2: if (i_clear) enter_clear();
         else if (dv && i_dump_ready) begin
           if (da == NR - 1) begin dv = 0; mode = 1; end
           else begin da++; dd = mem[da]; end
         end
      default: ;
    endcase
  endtask

  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) model_reset();
    else            model_step();
  end

  always @(negedge i_clk) begin
    if (cmp_en) begin
      check("ready", 32'(o_ready), 32'(mode != 0));
      for (int p = 0; p < NP; p++) check($sformatf("rd_p%0d", p), o_data[p*NB +: NB], ed[p]);
      check("dump_valid", 32'(o_dump_valid), 32'(dv));
      check("dump_last", 32'(o_dump_last), 32'(dv && da == NR - 1));
      if (dv || !i_reset_n) begin
        check("dump_addr", 32'(o_dump_addr), 32'(da));
        check("dump_data", o_dump_data, dd);
      end
    end
  end

  task automatic cyc();
    @(negedge i_clk); #1;
  endtask

  task automatic idle_in();
    i_write_enable = 0; i_write_strobe = '0; i_write_direc = '0; i_data = '0;
    i_read_direc = '0; i_clear = 0; i_dump_start = 0; i_dump_ready = 0;
  endtask

  task automatic wait_ready(input string name);
    int edges = 0;
    int seen_valid = 0;
    while (!o_ready && edges < 200) begin
      cyc(); edges++;
      if (o_dump_valid) seen_valid++;
    end
    check({name, "_edges"}, 32'(edges), 32'd31);
    check({name, "_novalid"}, 32'(seen_valid), 32'd0);
  endtask

  task automatic read_all_zero(input string name);
    for (int a = 0; a < NR; a += NP) begin
      i_read_direc = {AW'(a + 1), AW'(a)};
      cyc();
      check({name, "_p0"}, o_data[NB-1:0], 32'd0);
      check({name, "_p1"}, o_data[2*NB-1:NB], 32'd0);
    end
  endtask

  initial begin
    int acc, addr_err, last_err, cycles;
    bit wrote;
    idle_in();
    repeat (3) @(negedge i_clk);
    #1;
    cmp_en = 1;
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_data", o_data[NB-1:0], 32'd0);
    check("rst_dump_valid", 32'(o_dump_valid), 32'd0);
    i_reset_n = 1;
    wait_ready("reset");
    read_all_zero("init_rd");

    // Full write then single-byte update, read back through the bypass and the array.
    i_write_enable = 1; i_write_direc = 5; i_write_strobe = 4'b1111; i_data = 32'hDEADBEEF;
    cyc();
    i_write_strobe = 4'b0010; i_data = 32'h00001200; i_read_direc = {AW'(5), AW'(0)};
    cyc();
    check("bypass_p1", o_data[2*NB-1:NB], 32'hDEADBEEF & 32'hFFFF00FF | 32'h00001200);
    check("bypass_p1_lit", o_data[2*NB-1:NB], 32'hDEAD12EF);
    idle_in(); i_read_direc = {AW'(0), AW'(5)};
    cyc();
    check("merge_p0", o_data[NB-1:0], 32'hDEAD12EF);

    // r0 is immutable.
    i_write_enable = 1; i_write_direc = 0; i_write_strobe = '1; i_data = 32'hFFFFFFFF;
    i_read_direc = '0;
    cyc();
    check("r0_bypass_p0", o_data[NB-1:0], 32'd0);
    check("r0_bypass_p1", o_data[2*NB-1:NB], 32'd0);
    idle_in();
    cyc();
    check("r0_p0", o_data[NB-1:0], 32'd0);
    check("r0_p1", o_data[2*NB-1:NB], 32'd0);

    // Dump with ready toggling; r3 rewritten while word 3 is stalled.
    i_write_enable = 1; i_write_direc = 3; i_write_strobe = '1; i_data = 32'h33333333;
    cyc();
    idle_in(); i_dump_start = 1;
    cyc();
    i_dump_start = 0;
    check("dump_first_valid", 32'(o_dump_valid), 32'd1);
    acc = 0; addr_err = 0; last_err = 0; cycles = 0; wrote = 0;
    while (acc < NR && cycles < 400) begin
      i_write_enable = 0;
      i_dump_ready = cycles[0];
      if (o_dump_valid && o_dump_addr == 3 && !i_dump_ready && !wrote) begin
        i_write_enable = 1; i_write_direc = 3; i_write_strobe = '1; i_data = 32'hABCD0000;
        wrote = 1;
      end
      if (o_dump_valid && i_dump_ready) begin
        if (int'(o_dump_addr) != acc) addr_err++;
        if (o_dump_last != (acc == NR - 1)) last_err++;
        if (acc == 3) check("dump_w3_stale", o_dump_data, 32'h33333333);
        acc++;
      end
      cyc(); cycles++;
    end
    idle_in();
    check("dump_count", 32'(acc), 32'd32);
    check("dump_addr_seq", 32'(addr_err), 32'd0);
    check("dump_last_pos", 32'(last_err), 32'd0);
    check("dump_stall_write", 32'(wrote), 32'd1);
    check("dump_done_valid", 32'(o_dump_valid), 32'd0);
    i_read_direc = {AW'(0), AW'(3)};
    cyc();
    check("r3_after_dump", o_data[NB-1:0], 32'hABCD0000);

    // Clear beats a simultaneous dump request.
    idle_in(); i_clear = 1; i_dump_start = 1;
    cyc();
    idle_in();
    check("clr_ready_low", 32'(o_ready), 32'd0);
    wait_ready("clear");
    read_all_zero("clr_rd");

    // Reset while word 10 is presented.
    idle_in(); i_dump_start = 1;
    cyc();
    i_dump_start = 0; i_dump_ready = 1; cycles = 0;
    while (!(o_dump_valid && o_dump_addr == 10) && cycles < 100) begin
      cyc(); cycles++;
    end
    check("rstdump_at10", 32'(o_dump_addr), 32'd10);
    i_dump_ready = 0;
    #2 i_reset_n = 0;
    #1;
    check("rstdump_valid", 32'(o_dump_valid), 32'd0);
    check("rstdump_addr", 32'(o_dump_addr), 32'd0);
    check("rstdump_ready", 32'(o_ready), 32'd0);
    cyc();
    i_reset_n = 1;
    wait_ready("rst_mid_dump");

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      i_write_enable = ($urandom_range(0, 1) == 1);
      i_write_direc  = AW'($urandom_range(0, NR - 1));
      i_write_strobe = NS'($urandom);
      i_data         = $urandom;
      i_read_direc   = RW'($urandom);
      if ($urandom_range(0, 3) == 0) i_read_direc[AW-1:0] = i_write_direc;
      i_clear      = ($urandom_range(0, 299) == 0);
      i_dump_start = ($urandom_range(0, 39) == 0);
      i_dump_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    idle_in();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the MIPS datapath: one byte-maskable write port, `NUM_READ_PORTS` registered read ports with write-first bypass, and register 0 hardwired to zero. An internal sequencer clears the array after reset or on request, and streams the whole array out over a valid/ready dump port for the debug unit without stalling normal reads.

## Interface
- `NUM_BITS`, 32: data width; must be a multiple of 8.
- `NUM_REGS`, 32: number of registers; must be ≥ 2.
- `NUM_READ_PORTS`, 2: number of independent read ports; must be ≥ 1.
- `TAM_DIREC`, `$clog2(NUM_REGS)`: address width.
- `i_clk`  in  1  single clock; all state updates on the rising edge.
- `i_reset_n`  in  1  reset, asynchronous assert, active-low.
- `i_write_enable`  in  1  write request.
- `i_write_strobe`  in  NUM_BITS/8  byte enables; bit k covers data bits [8k+7:8k].
- `i_write_direc`  in  TAM_DIREC  write address.
- `i_data`  in  NUM_BITS  write data.
- `i_read_direc`  in  NUM_READ_PORTS*TAM_DIREC  packed read addresses; port p uses slice p.
- `o_data`  out  NUM_READ_PORTS*NUM_BITS  packed registered read data.
- `i_clear`  in  1  one-cycle request to zero the array.
- `o_ready`  out  1  high when the array is usable (state IDLE or DUMP).
- `i_dump_start`  in  1  one-cycle request to stream registers 0 to NUM_REGS-1.
- `o_dump_valid`  out  1  dump word present.
- `i_dump_ready`  in  1  consumer accepts the word when it is high together with `o_dump_valid`.
- `o_dump_addr`  out  TAM_DIREC  address of the presented word.
- `o_dump_data`  out  NUM_BITS  presented word.
- `o_dump_last`  out  1  presented word is register NUM_REGS-1.

## Operation
- States: CLEAR, IDLE, DUMP. Reset puts the block in CLEAR with the clear pointer at 1.
- CLEAR: zeroes one register per edge, covering registers 1 to NUM_REGS-1. The edge that clears NUM_REGS-1 also moves the state to IDLE. In CLEAR, writes and `i_dump_start` are ignored, all `o_data` slices read 0, and `o_ready` = 0.
- IDLE: `i_clear` moves to CLEAR with the pointer at 1. Otherwise `i_dump_start` moves to DUMP. If both are high in the same cycle, clear wins and the dump request is dropped.
- DUMP: the word at `o_dump_addr` is captured into `o_dump_data` when it is presented. It stays stable while `o_dump_valid && !i_dump_ready`, even if that register is written during the stall.
  - A handshake increments the address and captures the next word.
  - A handshake on the last word drops `o_dump_valid` and returns to IDLE.
  - `i_dump_start` is ignored during DUMP.
  - `i_clear` aborts the dump: `o_dump_valid` drops and the state goes to CLEAR.
  - Normal writes and reads continue during DUMP.
- Write: when `i_write_enable` is high, the address is not 0 and the state is not CLEAR, each byte with its strobe bit set is updated. A write to register 0 is ignored.
- Read, per port: the addressed word is registered on each edge. If the read address equals the write address and a write is active in the same cycle, the merged word (new bytes where strobed, old bytes elsewhere) is returned. Address 0 always returns 0.
- Dump capture uses the same bypass rule.
- Address ≥ NUM_REGS (non-power-of-2 depth): reads return 0 and writes are ignored.

## Timing
- Read latency is 1: the address driven before edge n appears on `o_data` after edge n.
- Write latency is 1: a write at edge n is visible to a read issued in the same cycle through the bypass.
- After `i_reset_n` deasserts, `o_ready` rises after NUM_REGS-1 edges (31 edges for the default depth). The same holds after `i_clear`, counted from the edge that samples it.
- A dump takes NUM_REGS handshakes. The first word is valid on the edge after `i_dump_start` is sampled.
- Reset values:
  - `o_data` = 0, `o_ready` = 0.
  - `o_dump_valid` = 0, `o_dump_addr` = 0, `o_dump_data` = 0, `o_dump_last` = 0.
  - Array contents are undefined until the CLEAR sequence completes.
- Reset asserted mid-CLEAR or mid-DUMP: outputs go to reset values immediately, the dump is lost, and CLEAR restarts from 1.

## Structure
- Shared package holds the state encodings (CLEAR, IDLE, DUMP) and the default `NUM_BITS` and `NUM_REGS` of the MIPS core.
- Sub-module `rf_dump_sequencer` owns the FSM, the clear pointer and the dump address/handshake logic. It exports the array clear-write address/enable and the dump read address.
- The array, write-merge and bypass logic stay in the top module.

## Test plan
- Reset release, `NUM_REGS`=32: `o_ready` stays 0 for 31 edges, then goes to 1. All read ports return 0 for addresses 0 to 31.
- Write `0xDEADBEEF` to r5 with strobe `4'b1111`, then write `0x00001200` to r5 with strobe `4'b0010`: reading r5 returns `0xDEAD12EF`. The second write is read in its own cycle with read port 1 at address 5, and port 1 shows `0xDEAD12EF` one edge later (bypass).
- Write `0xFFFFFFFF` to r0, then read r0 on every port: all return 0.
- Dump with `i_dump_ready` toggling every other cycle, and r3 written mid-stall while word 3 is presented:
  - 32 words are accepted with addresses 0 to 31, and `o_dump_last` is high only with address 31.
  - Word 3 keeps its pre-write value; a later read of r3 returns the new value.
- `i_clear` and `i_dump_start` in the same cycle: no dump words appear, `o_ready` is low for 31 edges, and all registers read 0 afterwards.
- `i_reset_n` pulsed low while a dump is presenting word 10: `o_dump_valid` drops immediately, CLEAR completes, and no further dump words appear.
